// File: rtl/alu_datapath_pkg.sv
// Shared constants for the ALU datapath responder:
// opcodes, strobe-sequence tracker states and flag bit positions.
package alu_datapath_pkg;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_AND = 4'b1010;
    localparam logic [3:0] OP_OR  = 4'b1011;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SHL = 4'b1101;
    localparam logic [3:0] OP_SHR = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        GOT_A,
        GOT_AB,
        RESULT
    } trk_state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_datapath_core.sv
// Combinational ALU: opcode and operands in, result and Z/C/N/V out.
// Undefined opcodes yield a zero result and raise bad_op.
module alu_core
    import alu_datapath_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   opcode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic [3:0]   flags,
    output logic         bad_op
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       c;
    logic       v;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        r      = '0;
        c      = 1'b0;
        v      = 1'b0;
        bad_op = 1'b0;
        case (opcode)
            OP_ADD: begin
                r = sum[W-1:0];
                c = sum[W];
                v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r = diff[W-1:0];
                // top bit of the widened difference is the borrow
                c = diff[W];
                v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                r = {a[W-2:0], 1'b0};
                c = a[W-1];
            end
            OP_SHR: begin
                r = {1'b0, a[W-1:1]};
                c = a[0];
            end
            default: bad_op = 1'b1;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (r == '0);
        flags[FLAG_C] = c;
        flags[FLAG_N] = r[W-1];
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_datapath.sv
// ALU responder: captures operands from the bus, registers the result,
// drives it back on request and flags out-of-order control strobes.
module alu_datapath
    import alu_datapath_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   opcode,
    input  logic         ALUin0,
    input  logic         ALUin1,
    input  logic         ALUoutlatch,
    input  logic         ALUoutEN,
    input  logic         done,
    input  logic         err_clr,
    input  logic [W-1:0] bus_in,
    output logic [W-1:0] bus_out,
    output logic         bus_oe,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_n,
    output logic         flag_v,
    output logic         res_valid,
    output logic         proto_err
);

    trk_state_t   state;
    trk_state_t   next_state;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] r_q;
    logic [3:0]   flags_q;
    logic [W-1:0] alu_r;
    logic [3:0]   alu_flags;
    logic         bad_op;
    logic         err_set;
    logic         valid_set;
    logic         valid_clr;

    alu_core #(.W(W)) u_core (
        .opcode (opcode),
        .a      (a_q),
        .b      (b_q),
        .r      (alu_r),
        .flags  (alu_flags),
        .bad_op (bad_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ALUin0 always restarts the sequence, whatever else is strobed
    always_comb begin
        next_state = state;
        if (ALUin0) begin
            next_state = GOT_A;
        end else begin
            case (state)
                GOT_A:   if (ALUin1) next_state = GOT_AB;
                GOT_AB:  if (ALUoutlatch) next_state = RESULT;
                RESULT:  if (done) next_state = IDLE;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        err_set = 1'b0;
        if (ALUin1 && !ALUin0 && state != GOT_A)
            err_set = 1'b1;
        if (ALUin0 && ALUin1)
            err_set = 1'b1;
        if (ALUoutlatch && (state != GOT_AB || bad_op))
            err_set = 1'b1;
        valid_clr = ALUin0;
        valid_set = ALUoutlatch && !ALUin0 && state == GOT_AB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            flags_q   <= '0;
            res_valid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (ALUin0)
                a_q <= bus_in;
            if (ALUin1)
                b_q <= bus_in;
            if (ALUoutlatch) begin
                r_q     <= alu_r;
                flags_q <= alu_flags;
            end
            if (valid_clr)
                res_valid <= 1'b0;
            else if (valid_set)
                res_valid <= 1'b1;
            if (err_set)
                proto_err <= 1'b1;
            else if (err_clr)
                proto_err <= 1'b0;
        end
    end

    assign bus_oe  = ALUoutEN;
    assign bus_out = ALUoutEN ? r_q : '0;
    assign flag_z  = flags_q[FLAG_Z];
    assign flag_c  = flags_q[FLAG_C];
    assign flag_n  = flags_q[FLAG_N];
    assign flag_v  = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_datapath.sv
// Directed and random checks of alu_datapath against an
// arithmetic reference model of the strobe protocol.
module tb_alu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        ALUin0;
    logic        ALUin1;
    logic        ALUoutlatch;
    logic        ALUoutEN;
    logic        done;
    logic        err_clr;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic        flag_z;
    logic        flag_c;
    logic        flag_n;
    logic        flag_v;
    logic        res_valid;
    logic        proto_err;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state; ph counts in-order strobes seen (0..3)
    logic [15:0] m_a, m_b, m_r;
    logic        m_z, m_c, m_n, m_v;
    logic        m_valid, m_err;
    int          ph;

    alu_datapath #(.W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .ALUin0      (ALUin0),
        .ALUin1      (ALUin1),
        .ALUoutlatch (ALUoutlatch),
        .ALUoutEN    (ALUoutEN),
        .done        (done),
        .err_clr     (err_clr),
        .bus_in      (bus_in),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_n      (flag_n),
        .flag_v      (flag_v),
        .res_valid   (res_valid),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_r = 0;
        m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        m_valid = 0; m_err = 0; ph = 0;
    endtask

    task automatic ref_alu(input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, output logic [15:0] r,
                           output logic c, output logic v);
        int ua, ub, sa, sb, s, ss;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 0; c = 0; v = 0;
        case (int'(op))
            8: begin
                s = ua + ub; r = 16'(s); c = s > 65535;
                ss = sa + sb; v = ss > 32767 || ss < -32768;
            end
            9: begin
                s = ua - ub; r = 16'(s); c = ua < ub;
                ss = sa - sb; v = ss > 32767 || ss < -32768;
            end
            10: r = a & b;
            11: r = a | b;
            12: r = a ^ b;
            13: begin r = 16'(ua * 2); c = ua >= 32768; end
            14: begin r = 16'(ua / 2); c = (ua % 2) == 1; end
            default: r = 0;
        endcase
    endtask

    task automatic model_clk(input logic i0, i1, lat, dn, clr,
                             input logic [3:0] op, input logic [15:0] bus);
        logic [15:0] r;
        logic c, v, bad, err;
        bad = op < 4'd8 || op > 4'd14;
        err = (i1 && !i0 && ph != 1) || (i0 && i1) ||
              (lat && (ph != 2 || bad));
        if (lat) begin
            ref_alu(op, m_a, m_b, r, c, v);
            m_r = r; m_c = c; m_v = v;
            m_z = (r == 0); m_n = r[15];
        end
        if (i0) m_a = bus;
        if (i1) m_b = bus;
        if (i0) begin
            ph = 1; m_valid = 0;
        end else if (i1 && ph == 1) begin
            ph = 2;
        end else if (lat && ph == 2) begin
            ph = 3; m_valid = 1;
        end else if (dn && ph == 3) begin
            ph = 0;
        end
        if (err) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bus_out"}, bus_out, ALUoutEN ? m_r : 16'h0);
        chk({tag, ".bus_oe"}, 16'(bus_oe), 16'(ALUoutEN));
        chk({tag, ".flags"}, {12'h0, flag_z, flag_c, flag_n, flag_v},
            {12'h0, m_z, m_c, m_n, m_v});
        chk({tag, ".res_valid"}, 16'(res_valid), 16'(m_valid));
        chk({tag, ".proto_err"}, 16'(proto_err), 16'(m_err));
    endtask

    // one clock: drive at negedge, check comb output, clock, check regs
    task automatic step(input logic i0, i1, lat, en, dn, clr,
                        input logic [3:0] op, input logic [15:0] bus);
        ALUin0 = i0; ALUin1 = i1; ALUoutlatch = lat;
        ALUoutEN = en; done = dn; err_clr = clr;
        opcode = op; bus_in = bus;
        #1;
        chk("pre.bus_out", bus_out, en ? m_r : 16'h0);
        @(posedge clk);
        model_clk(i0, i1, lat, dn, clr, op, bus);
        #1;
        check_all("post");
        @(negedge clk);
    endtask

    task automatic seq(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
        step(1, 0, 0, 0, 0, 0, 4'h0, a);
        step(0, 1, 0, 0, 0, 0, 4'h0, b);
        step(0, 0, 1, 0, 0, 0, op, 16'h0);
        step(0, 0, 0, 1, 0, 0, 4'h0, 16'h0);
        step(0, 0, 0, 0, 1, 0, 4'h0, 16'h0);
    endtask

    task automatic show_r(input string tag, input logic [15:0] exp);
        ALUoutEN = 1'b1;
        #1;
        chk(tag, bus_out, exp);
        ALUoutEN = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] bv;
        rst = 1'b1;
        ALUin0 = 0; ALUin1 = 0; ALUoutlatch = 0;
        ALUoutEN = 0; done = 0; err_clr = 0;
        opcode = 0; bus_in = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        seq(16'h7FFF, 16'h0001, 4'b1000);
        show_r("add.r", 16'h8000);
        chk("add.nvcz", {12'h0, flag_n, flag_v, flag_c, flag_z},
            16'b1100);
        chk("add.valid", 16'(res_valid), 16'h1);
        chk("add.err", 16'(proto_err), 16'h0);

        seq(16'h0003, 16'h0005, 4'b1001);
        show_r("sub.r", 16'hFFFE);
        chk("sub.cnv", {13'h0, flag_c, flag_n, flag_v}, 16'b110);

        seq(16'hF0F0, 16'h0FF0, 4'b1010);
        show_r("and.r", 16'h00F0);
        seq(16'hA5C3, 16'hA5C3, 4'b1100);
        show_r("xor.r", 16'h0000);
        chk("xor.z", 16'(flag_z), 16'h1);
        seq(16'h8001, 16'h0000, 4'b1101);
        show_r("shl.r", 16'h0002);
        chk("shl.c", 16'(flag_c), 16'h1);
        chk("seq.err", 16'(proto_err), 16'h0);

        step(0, 1, 0, 0, 0, 0, 4'h0, 16'h1111);
        chk("early_b.err", 16'(proto_err), 16'h1);
        step(0, 0, 0, 0, 0, 0, 4'h0, 16'h0);
        chk("early_b.sticky", 16'(proto_err), 16'h1);
        step(0, 0, 0, 0, 0, 1, 4'h0, 16'h0);
        chk("clr.err", 16'(proto_err), 16'h0);

        seq(16'h0005, 16'h0006, 4'b0111);
        show_r("badop.r", 16'h0000);
        chk("badop.z", 16'(flag_z), 16'h1);
        chk("badop.err", 16'(proto_err), 16'h1);
        step(0, 0, 0, 0, 0, 1, 4'h0, 16'h0);

        seq(16'h0001, 16'h0001, 4'b1000);
        step(1, 0, 0, 0, 0, 0, 4'h0, 16'h1234);
        step(0, 1, 0, 1, 0, 0, 4'h0, 16'h5678);
        chk("rst.pre_bus", bus_out, 16'h0002);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst.bus", bus_out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 0, 0, 4'b1000, 16'h0);
        chk("rst.latch_err", 16'(proto_err), 16'h1);
        step(0, 0, 0, 0, 0, 1, 4'h0, 16'h0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: bv = 16'h0000;
                1: bv = 16'hFFFF;
                2: bv = 16'h8000;
                default: bv = 16'($urandom);
            endcase
            step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0 ? 4'($urandom)
                                           : 4'($urandom_range(8, 14)),
                 bv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Responder side of the ALU control strobes. It captures operands from the shared data bus on `ALUin0`/`ALUin1` and computes the result for the 4-bit ALU opcode on `ALUoutlatch`. It drives the result onto the bus on `ALUoutEN` and tracks the strobe sequence so that out-of-order control is flagged. It sits between the general-register bus and the ALU control FSM, which sequences it.

## Interface
- `W`, 16, datapath and bus width (≥ 2)
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `opcode`  in  4  instruction[15:12]; sampled only on the `ALUoutlatch` edge
- `ALUin0`  in  1  capture `bus_in` into operand A
- `ALUin1`  in  1  capture `bus_in` into operand B
- `ALUoutlatch`  in  1  compute and register the result and flags
- `ALUoutEN`  in  1  drive the result onto the bus
- `done`  in  1  end of instruction from the control FSM
- `err_clr`  in  1  clear `proto_err`
- `bus_in`  in  W  shared data bus (register-file output)
- `bus_out`  out  W  result when `bus_oe`, else 0
- `bus_oe`  out  1  equals `ALUoutEN` (combinational)
- `flag_z`, `flag_c`, `flag_n`, `flag_v`  out  1 each  registered status flags
- `res_valid`  out  1  result register holds the result of a completed sequence
- `proto_err`  out  1  sticky strobe-sequence violation

## Operation
- **Registers:** `A`, `B`, `R` (W bits each) and 4 flags. All of them, plus `res_valid` and `proto_err`, reset to 0.
- **Sequence tracker states:**
  - `IDLE`: reset state.
  - `GOT_A`: entered on `ALUin0`, from any state. This restarts the sequence and clears `res_valid`.
  - `GOT_AB`: entered on `ALUin1` in `GOT_A`.
  - `RESULT`: entered on `ALUoutlatch` in `GOT_AB`. Sets `res_valid`.
  - `RESULT` returns to `IDLE` on `done`. `res_valid` and `R` are held.
- **Protocol violations** set `proto_err`:
  - `ALUin1` outside `GOT_A`: B still loads; state unchanged.
  - `ALUoutlatch` outside `GOT_AB`: R and flags still update; state unchanged.
  - `ALUin0` and `ALUin1` high together: both load `bus_in`; state goes to `GOT_A`.
  - Opcode outside 1000–1110 at latch: R = 0, Z = 1, C = N = V = 0.
- **Clearing `proto_err`:** `err_clr` clears it. If `err_clr` and a new violation occur in the same cycle, the set wins.
- **Opcodes:** results are modulo 2^W. The A/B operands are the register values at the latch edge.
  - 1000 ADD, R = A + B: C = carry out; V = signed overflow.
  - 1001 SUB, R = A − B: C = borrow (A < B unsigned); V = signed overflow.
  - 1010 AND.
  - 1011 OR.
  - 1100 XOR.
  - 1101 SHL, R = A << 1: C = A[W−1].
  - 1110 SHR (logical), R = A >> 1: C = A[0].
  - Logic ops and shifts: C = 0 (except shifts as above), V = 0.
  - All ops: Z = (R == 0), N = R[W−1].
- **Bus output:** `bus_out` = `bus_oe` ? R : 0. No internal tri-state.

## Timing
- Operand capture happens at the rising edge where the strobe is high. The value captured is `bus_in` during that cycle.
- Result latency: R and flags are valid the cycle after the `ALUoutlatch` edge.
- Bus drive: `bus_out` follows R combinationally while `ALUoutEN` is high, so a register write enabled in the same cycle captures R.
- `ALUoutEN` together with `ALUoutlatch` in one cycle: `bus_out` shows the old R during that cycle.
- Strobes held for multiple cycles re-capture every cycle. A repeated `ALUin0` keeps the state in `GOT_A` (no error). A repeated `ALUoutlatch` in `RESULT` sets `proto_err`.
- `done` outside `RESULT` is ignored.
- Reset mid-sequence: all registers clear immediately. `bus_out` is 0 unless `ALUoutEN` is high, in which case it is 0 because R = 0.

## Structure
- **Shared package:** opcode constants (`OP_ADD`..`OP_SHR`), tracker state enum, flag index constants.
- **Sub-module:** combinational `alu_core` (opcode, A, B → R, Z, C, N, V). The tracker and registers stay in `alu_datapath`.

## Test plan
- **ADD overflow:** A = 0x7FFF, B = 0x0001, op 1000 → R = 0x8000, N = 1, V = 1, C = 0, Z = 0; `res_valid` = 1; `bus_out` = 0x8000 while `ALUoutEN` is high.
- **SUB borrow:** A = 0x0003, B = 0x0005, op 1001 → R = 0xFFFE, C = 1, N = 1, V = 0.
- **Logic and shift:**
  - 0xF0F0 AND 0x0FF0 → 0x00F0.
  - XOR of equal operands → 0x0000, Z = 1.
  - SHL A = 0x8001 → 0x0002, C = 1.
- **Full sequence:** strobes in order ALUin0, ALUin1, ALUoutlatch, ALUoutEN, done → tracker visits `GOT_A`, `GOT_AB`, `RESULT`, `IDLE`; `proto_err` stays 0.
- **Protocol error:**
  - `ALUin1` before `ALUin0` → `proto_err` = 1 next cycle and stays 1.
  - `err_clr` → 0.
  - Opcode 0111 at latch → R = 0, Z = 1, `proto_err` = 1.
- **Reset mid-op:** assert `rst` in `GOT_AB` with A = 0x1234 → all outputs 0 asynchronously. The next `ALUoutlatch` without new operands flags `proto_err`.
